// File: rtl/mem_access_seq.sv
// Data-memory access sequencer for the MEM stage.
// One stage request becomes one dcache transaction (plain or byte), or two
// for an indirect access: first the pointer fetch, then the access itself.
// The pipeline stalls until completion, and a one-cycle rsp_valid pulse
// reports it. An optional bounded wait aborts a dcache access that hangs.
module mem_access_seq #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int INDIRECT_EN = 1,
    parameter int TIMEOUT     = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic                  req_indirect,
    input  logic                  req_byte,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic [ADDR_W-1:0]     dmem_address,
    output logic                  dmem_read,
    output logic                  dmem_write,
    output logic [DATA_W-1:0]     dmem_wdata,
    output logic [DATA_W/8-1:0]   dmem_byte_enable,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_resp,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err
);

    localparam int LANES = DATA_W / 8;
    localparam int LB    = $clog2(LANES);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PTR  = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_byte;
    logic                r_read;
    logic                r_write;
    logic                r_conflict;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_need;
    logic                w_timeout;
    logic                w_abort;
    logic                w_capture;
    logic                w_ptr_load;
    logic                w_load_en;
    logic [LB-1:0]       w_lane;
    logic [ADDR_W-1:0]   w_addr_aligned;
    logic [LANES-1:0]    w_be_byte;
    logic [DATA_W-1:0]   w_wdata_rep;
    logic [7:0]          w_lane_bytes [LANES];
    logic [DATA_W-1:0]   w_load_result;

    assign w_need         = req_valid & (req_read | req_write);
    assign w_lane         = r_addr[LB-1:0];
    assign w_addr_aligned = {r_addr[ADDR_W-1:LB], {LB{1'b0}}};
    // A timeout only aborts when the dcache did not answer in that same cycle.
    assign w_timeout      = (TIMEOUT != 0) && (r_cnt == TO_VAL);
    assign w_abort        = w_timeout & ~dmem_resp;

    // Per-lane byte enable, store-byte replication and load-lane split.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_be_byte[gi]            = (w_lane == LB'(gi));
            assign w_wdata_rep[gi*8 +: 8]   = r_wdata[7:0];
            assign w_lane_bytes[gi]         = dmem_rdata[gi*8 +: 8];
        end
    endgenerate

    assign w_load_result = r_byte ? {{(DATA_W-8){1'b0}}, w_lane_bytes[w_lane]} : dmem_rdata;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, dcache strobes, stall and the response pulse.
    always_comb begin
        w_state_next     = r_state;
        dmem_address     = '0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_wdata       = '0;
        dmem_byte_enable = '0;
        stall            = 1'b0;
        rsp_valid        = 1'b0;
        rsp_err          = 1'b0;
        w_capture        = 1'b0;
        w_ptr_load       = 1'b0;
        w_load_en        = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_need;
                if (w_need) begin
                    w_capture    = 1'b1;
                    w_state_next = (req_indirect && (INDIRECT_EN != 0)) ? S_PTR : S_ACC;
                end
            end
            S_PTR: begin
                stall = 1'b1;
                if (!w_abort) begin
                    dmem_read        = 1'b1;
                    dmem_address     = w_addr_aligned;
                    dmem_byte_enable = '1;
                end
                if (dmem_resp) begin
                    w_ptr_load   = 1'b1;
                    w_state_next = S_ACC;
                end else if (w_abort) begin
                    stall        = 1'b0;
                    rsp_valid    = 1'b1;
                    rsp_err      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_ACC: begin
                stall = 1'b1;
                if (!w_abort) begin
                    dmem_read  = r_read;
                    dmem_write = r_write;
                    if (r_byte) begin
                        dmem_address     = r_addr;
                        dmem_byte_enable = w_be_byte;
                        dmem_wdata       = w_wdata_rep;
                    end else begin
                        dmem_address     = w_addr_aligned;
                        dmem_byte_enable = '1;
                        dmem_wdata       = r_wdata;
                    end
                end
                if (dmem_resp) begin
                    stall        = 1'b0;
                    rsp_valid    = 1'b1;
                    rsp_err      = r_conflict;
                    w_load_en    = r_read;
                    w_state_next = S_IDLE;
                end else if (w_abort) begin
                    stall        = 1'b0;
                    rsp_valid    = 1'b1;
                    rsp_err      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request capture; the pointer fetch result replaces the address.
    // A read+write request is demoted to a plain read flagged as a conflict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_byte     <= 1'b0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_conflict <= 1'b0;
        end else if (w_capture) begin
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_byte     <= req_byte;
            r_read     <= req_read;
            r_write    <= req_write & ~req_read;
            r_conflict <= req_read & req_write;
        end else if (w_ptr_load) begin
            r_addr     <= dmem_rdata[ADDR_W-1:0];
        end
    end

    // Load result register, only updated by completing loads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_data <= '0;
        end else if (w_load_en) begin
            r_rsp_data <= w_load_result;
        end
    end

    // Wait counter: cleared on entry to a dcache phase, counts unanswered cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if ((w_state_next != r_state) && (w_state_next != S_IDLE)) begin
            r_cnt <= '0;
        end else if ((r_state != S_IDLE) && !dmem_resp) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign rsp_data = r_rsp_data;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq. Three instances share the request and
// dcache-answer inputs: u_dut0 (defaults), u_dut1 (INDIRECT_EN=0) and
// u_dut2 (TIMEOUT=4). Each test resets all of them and watches one.
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_read, req_write, req_indirect, req_byte;
    logic [15:0] req_addr, req_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;

    logic [15:0] addr_o  [3];
    logic [15:0] wdata_o [3];
    logic [15:0] rdat_o  [3];
    logic [1:0]  be_o    [3];
    logic        rd_o    [3];
    logic        wr_o    [3];
    logic        stall_o [3];
    logic        val_o   [3];
    logic        err_o   [3];

    int total = 0;
    int bad   = 0;

    // Per-transaction observations
    int          n_stall, n_rd, n_wr, n_val, n_err, n_cyc, ph;
    logic [15:0] a_ph  [2];
    logic [1:0]  be_ph [2];
    logic [15:0] wd_ph [2];

    always #5 clk = ~clk;

    mem_access_seq #(.DATA_W(16), .ADDR_W(16), .INDIRECT_EN(1), .TIMEOUT(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_indirect(req_indirect), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata), .dmem_address(addr_o[0]),
        .dmem_read(rd_o[0]), .dmem_write(wr_o[0]), .dmem_wdata(wdata_o[0]),
        .dmem_byte_enable(be_o[0]), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .stall(stall_o[0]), .rsp_valid(val_o[0]), .rsp_data(rdat_o[0]), .rsp_err(err_o[0]));

    mem_access_seq #(.DATA_W(16), .ADDR_W(16), .INDIRECT_EN(0), .TIMEOUT(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_indirect(req_indirect), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata), .dmem_address(addr_o[1]),
        .dmem_read(rd_o[1]), .dmem_write(wr_o[1]), .dmem_wdata(wdata_o[1]),
        .dmem_byte_enable(be_o[1]), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .stall(stall_o[1]), .rsp_valid(val_o[1]), .rsp_data(rdat_o[1]), .rsp_err(err_o[1]));

    mem_access_seq #(.DATA_W(16), .ADDR_W(16), .INDIRECT_EN(1), .TIMEOUT(4)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_indirect(req_indirect), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata), .dmem_address(addr_o[2]),
        .dmem_read(rd_o[2]), .dmem_write(wr_o[2]), .dmem_wdata(wdata_o[2]),
        .dmem_byte_enable(be_o[2]), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .stall(stall_o[2]), .rsp_valid(val_o[2]), .rsp_data(rdat_o[2]), .rsp_err(err_o[2]));

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        dmem_resp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Runs one request against instance sel. The dcache answers on the lat-th
    // strobe cycle of each phase (lat=0: never); r0/r1 are the phase read data.
    task automatic do_txn(input int sel, input logic [15:0] addr, input logic rd, input logic wr,
                          input logic ind, input logic byt, input logic [15:0] wd,
                          input int lat, input logic [15:0] r0, input logic [15:0] r1);
        int   wcnt;
        logic done;
        req_valid = 1'b1; req_read = rd; req_write = wr; req_indirect = ind;
        req_byte = byt; req_addr = addr; req_wdata = wd;
        n_stall = 0; n_rd = 0; n_wr = 0; n_val = 0; n_err = 0; n_cyc = 0; ph = 0;
        a_ph[0] = '0; a_ph[1] = '0; be_ph[0] = '0; be_ph[1] = '0; wd_ph[0] = '0; wd_ph[1] = '0;
        wcnt = 0;
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            dmem_resp  = 1'b0;
            dmem_rdata = 16'h0000;
            if (rd_o[sel] || wr_o[sel]) begin
                wcnt++;
                if (ph < 2) begin
                    a_ph[ph] = addr_o[sel]; be_ph[ph] = be_o[sel]; wd_ph[ph] = wdata_o[sel];
                end
                if (lat != 0 && wcnt == lat) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = (ph == 0) ? r0 : r1;
                    wcnt = 0;
                    ph++;
                end
            end
            #1;
            n_cyc++;
            if (stall_o[sel]) n_stall++;
            if (rd_o[sel]) n_rd++;
            if (wr_o[sel]) n_wr++;
            if (val_o[sel]) begin
                n_val++;
                if (err_o[sel]) n_err++;
                done = 1'b1;
            end
            @(negedge clk);
        end
        dmem_resp = 1'b0;
        req_valid = 1'b0;
        $display("txn dut%0d addr=%h rd=%b wr=%b ind=%b byte=%b cycles=%0d stall=%0d phases=%0d", sel, addr, rd, wr, ind, byt, n_cyc, n_stall, ph);
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL txn_complete dut%0d addr=%h: got no rsp_valid, want one within 30 cycles", sel, addr); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_indirect = 1'b0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;
        dmem_resp = 1'b0; dmem_rdata = '0;
        @(negedge clk);
        total++; if (stall_o[0] !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_o[0]); end
        total++; if ({rd_o[0], wr_o[0]} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b want=00", {rd_o[0], wr_o[0]}); end
        total++; if (be_o[0] !== 2'b00) begin bad++; $display("FAIL reset_be got=%b want=00", be_o[0]); end
        total++; if ({val_o[0], err_o[0]} !== 2'b00) begin bad++; $display("FAIL reset_rsp got=%b want=00", {val_o[0], err_o[0]}); end
        total++; if (rdat_o[0] !== 16'h0000) begin bad++; $display("FAIL reset_rsp_data got=%h want=0000", rdat_o[0]); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_load();
        do_reset();
        do_txn(0, 16'h1235, 1, 0, 0, 0, 16'h0000, 4, 16'hBEEF, 16'h0000);
        total++; if (a_ph[0] !== 16'h1234) begin bad++; $display("FAIL word_addr got=%h want=1234", a_ph[0]); end
        total++; if (be_ph[0] !== 2'b11) begin bad++; $display("FAIL word_be got=%b want=11", be_ph[0]); end
        total++; if (n_stall != 4) begin bad++; $display("FAIL word_stall got=%0d want=4", n_stall); end
        total++; if (n_rd != 4 || n_wr != 0) begin bad++; $display("FAIL word_strobes rd=%0d wr=%0d want rd=4 wr=0", n_rd, n_wr); end
        total++; if (n_val != 1 || n_err != 0) begin bad++; $display("FAIL word_rsp val=%0d err=%0d want 1/0", n_val, n_err); end
        total++; if (rdat_o[0] !== 16'hBEEF) begin bad++; $display("FAIL word_data got=%h want=beef", rdat_o[0]); end
    endtask

    task automatic test_byte_store();
        do_reset();
        do_txn(0, 16'h0100, 1, 0, 0, 0, 16'h0000, 1, 16'h1357, 16'h0000);
        total++; if (rdat_o[0] !== 16'h1357) begin bad++; $display("FAIL bst_preload got=%h want=1357", rdat_o[0]); end
        do_txn(0, 16'h2001, 0, 1, 0, 1, 16'h00A5, 1, 16'hFFFF, 16'h0000);
        total++; if (be_ph[0] !== 2'b10) begin bad++; $display("FAIL bst_be got=%b want=10", be_ph[0]); end
        total++; if (wd_ph[0] !== 16'hA5A5) begin bad++; $display("FAIL bst_wdata got=%h want=a5a5", wd_ph[0]); end
        total++; if (a_ph[0] !== 16'h2001) begin bad++; $display("FAIL bst_addr got=%h want=2001", a_ph[0]); end
        total++; if (n_wr != 1 || n_rd != 0) begin bad++; $display("FAIL bst_strobes wr=%0d rd=%0d want 1/0", n_wr, n_rd); end
        total++; if (rdat_o[0] !== 16'h1357) begin bad++; $display("FAIL bst_rsp_data got=%h want=1357", rdat_o[0]); end
    endtask

    task automatic test_byte_load();
        do_reset();
        do_txn(0, 16'h3000, 1, 0, 0, 1, 16'h0000, 1, 16'h80FF, 16'h0000);
        total++; if (be_ph[0] !== 2'b01) begin bad++; $display("FAIL bld0_be got=%b want=01", be_ph[0]); end
        total++; if (rdat_o[0] !== 16'h00FF) begin bad++; $display("FAIL bld0_data got=%h want=00ff", rdat_o[0]); end
        do_txn(0, 16'h3001, 1, 0, 0, 1, 16'h0000, 1, 16'h80FF, 16'h0000);
        total++; if (a_ph[0] !== 16'h3001) begin bad++; $display("FAIL bld1_addr got=%h want=3001", a_ph[0]); end
        total++; if (rdat_o[0] !== 16'h0080) begin bad++; $display("FAIL bld1_data got=%h want=0080", rdat_o[0]); end
    endtask

    task automatic test_indirect();
        do_reset();
        do_txn(0, 16'h4000, 1, 0, 1, 0, 16'h0000, 1, 16'h5000, 16'h1111);
        total++; if (ph != 2 || n_rd != 2) begin bad++; $display("FAIL ind_phases got ph=%0d rd=%0d want 2/2", ph, n_rd); end
        total++; if (a_ph[0] !== 16'h4000 || a_ph[1] !== 16'h5000) begin bad++; $display("FAIL ind_addrs got=%h,%h want=4000,5000", a_ph[0], a_ph[1]); end
        total++; if (n_cyc != 3) begin bad++; $display("FAIL ind_latency got=%0d want=3", n_cyc); end
        total++; if (rdat_o[0] !== 16'h1111) begin bad++; $display("FAIL ind_data got=%h want=1111", rdat_o[0]); end
        do_reset();
        do_txn(1, 16'h4000, 1, 0, 1, 0, 16'h0000, 1, 16'h5000, 16'h1111);
        total++; if (ph != 1 || a_ph[0] !== 16'h4000) begin bad++; $display("FAIL noind_phase got ph=%0d addr=%h want 1/4000", ph, a_ph[0]); end
        total++; if (n_cyc != 2) begin bad++; $display("FAIL noind_latency got=%0d want=2", n_cyc); end
        total++; if (rdat_o[1] !== 16'h5000) begin bad++; $display("FAIL noind_data got=%h want=5000", rdat_o[1]); end
    endtask

    task automatic test_conflict();
        do_reset();
        do_txn(0, 16'h0042, 1, 1, 0, 0, 16'h9999, 1, 16'h2468, 16'h0000);
        total++; if (n_wr != 0 || n_rd != 1) begin bad++; $display("FAIL conf_strobes wr=%0d rd=%0d want 0/1", n_wr, n_rd); end
        total++; if (n_err != 1) begin bad++; $display("FAIL conf_err got=%0d want=1", n_err); end
        total++; if (rdat_o[0] !== 16'h2468) begin bad++; $display("FAIL conf_data got=%h want=2468", rdat_o[0]); end
        // Request with neither read nor write: no stall, no strobe.
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0;
        #1;
        total++; if ({stall_o[0], rd_o[0], wr_o[0], val_o[0]} !== 4'b0000) begin bad++; $display("FAIL nop_req got=%b want=0000", {stall_o[0], rd_o[0], wr_o[0], val_o[0]}); end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        do_txn(2, 16'h0600, 1, 0, 0, 0, 16'h0000, 1, 16'h7777, 16'h0000);
        total++; if (rdat_o[2] !== 16'h7777) begin bad++; $display("FAIL to_preload got=%h want=7777", rdat_o[2]); end
        do_txn(2, 16'h0700, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        total++; if (n_rd != 4) begin bad++; $display("FAIL to_strobe_cycles got=%0d want=4", n_rd); end
        total++; if (n_val != 1 || n_err != 1) begin bad++; $display("FAIL to_rsp val=%0d err=%0d want 1/1", n_val, n_err); end
        total++; if (n_stall != 5) begin bad++; $display("FAIL to_stall got=%0d want=5", n_stall); end
        total++; if (rdat_o[2] !== 16'h7777) begin bad++; $display("FAIL to_rsp_data got=%h want=7777", rdat_o[2]); end
        #1;
        total++; if ({stall_o[2], rd_o[2], val_o[2]} !== 3'b000) begin bad++; $display("FAIL to_idle got=%b want=000", {stall_o[2], rd_o[2], val_o[2]}); end
        @(negedge clk);
        do_txn(2, 16'h0A00, 1, 0, 0, 0, 16'h0000, 1, 16'h0AAA, 16'h0000);
        total++; if (n_cyc != 2 || rdat_o[2] !== 16'h0AAA) begin bad++; $display("FAIL to_recover cycles=%0d data=%h want 2/0aaa", n_cyc, rdat_o[2]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_indirect = 1'b0;
        req_byte = 1'b0; req_addr = 16'h0800; dmem_resp = 1'b0;
        @(negedge clk);
        #1;
        total++; if (rd_o[0] !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b want=1", rd_o[0]); end
        reset_n = 1'b0;
        #1;
        total++; if ({rd_o[0], val_o[0]} !== 2'b00) begin bad++; $display("FAIL midrst_drop got=%b want=00", {rd_o[0], val_o[0]}); end
        req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        do_txn(0, 16'h0900, 1, 0, 0, 0, 16'h0000, 1, 16'hA1A1, 16'h0000);
        total++; if (n_cyc != 2 || rdat_o[0] !== 16'hA1A1) begin bad++; $display("FAIL b2b_0 cycles=%0d data=%h want 2/a1a1", n_cyc, rdat_o[0]); end
        do_txn(0, 16'h0902, 1, 0, 0, 0, 16'h0000, 1, 16'hB2B2, 16'h0000);
        total++; if (n_cyc != 2 || rdat_o[0] !== 16'hB2B2) begin bad++; $display("FAIL b2b_1 cycles=%0d data=%h want 2/b2b2", n_cyc, rdat_o[0]); end
        do_txn(0, 16'h0905, 1, 0, 0, 1, 16'h0000, 1, 16'hC3D4, 16'h0000);
        total++; if (n_cyc != 2 || rdat_o[0] !== 16'h00C3) begin bad++; $display("FAIL b2b_2 cycles=%0d data=%h want 2/00c3", n_cyc, rdat_o[0]); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_indirect();
        test_conflict();
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
